// File: rtl/instr_encoder_loader_if.sv
// Field-bundle stream into the encoder plus the instruction-memory write bus out of it.
// The host/boot side uses master; the encoder uses slave.
interface instr_encoder_loader_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4:0]            in_opcode;
  logic [4:0]            in_rd;
  logic [4:0]            in_rs;
  logic [4:0]            in_rt;
  logic [4:0]            in_shamt;
  logic [4:0]            in_aluop;
  logic [16:0]           in_imm;
  logic [26:0]           in_target;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_data;

  modport master (
    output in_valid, in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop, in_imm, in_target,
    input  in_ready, imem_we, imem_addr, imem_data
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop, in_imm, in_target,
    output in_ready, imem_we, imem_addr, imem_data
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs decoded instruction fields into 32-bit ISA words and writes them to
// instruction memory at consecutive addresses, framed by a load-session FSM.
module instr_encoder_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int MAX_WORDS  = 4096
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  finish,
  instr_encoder_loader_if.slave bus,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  err_opcode,
  output logic                  err_overflow
);

  localparam logic [ADDR_WIDTH:0] MAX_COUNT = (ADDR_WIDTH+1)'(MAX_WORDS);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t                state, state_next;
  logic [31:0]           enc_word;
  logic                  enc_ok;
  logic [ADDR_WIDTH:0]   fill;
  logic                  full;
  logic                  accept;
  logic                  session_open;

  // The imem output registers double as the single pending stage, so the
  // next free address is the committed count plus any word being written now.
  assign fill         = word_count + {{ADDR_WIDTH{1'b0}}, bus.imem_we};
  assign full         = (fill >= MAX_COUNT);
  assign bus.in_ready = (state == LOAD) && !full;
  assign accept       = bus.in_valid && bus.in_ready;
  assign session_open = (state == IDLE) && start;
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

  always_comb begin
    enc_word = 32'd0;
    enc_ok   = 1'b1;
    case (bus.in_opcode)
      5'b00000:
        enc_word = {bus.in_opcode, bus.in_rd, bus.in_rs, bus.in_rt,
                    bus.in_shamt, bus.in_aluop, 2'b00};
      5'b00101, 5'b00111, 5'b01000, 5'b00010, 5'b00110:
        enc_word = {bus.in_opcode, bus.in_rd, bus.in_rs, bus.in_imm};
      5'b00001, 5'b00011, 5'b10101, 5'b10110:
        enc_word = {bus.in_opcode, bus.in_target};
      5'b00100:
        enc_word = {bus.in_opcode, bus.in_rd, 22'd0};
      default:
        enc_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    if (finish) state_next = DRAIN;
      DRAIN:   if (!bus.imem_we) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= IDLE;
      bus.imem_we   <= 1'b0;
      bus.imem_addr <= '0;
      bus.imem_data <= 32'd0;
      word_count    <= '0;
      err_opcode    <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      state       <= state_next;
      bus.imem_we <= accept && enc_ok;
      if (accept && enc_ok) begin
        bus.imem_addr <= fill[ADDR_WIDTH-1:0];
        bus.imem_data <= enc_word;
      end
      if (session_open) begin
        word_count   <= '0;
        err_opcode   <= 1'b0;
        err_overflow <= 1'b0;
      end else begin
        word_count <= fill;
        if (accept && !enc_ok)
          err_opcode <= 1'b1;
        if ((state == LOAD) && bus.in_valid && full)
          err_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: encoding, sessions, bad opcodes,
// full-session overflow, finish-with-beat and mid-session reset.
module tb_instr_encoder_loader;

  localparam int AW = 12;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic          finish;
  logic          busy;
  logic          done;
  logic [AW:0]   word_count;
  logic          err_opcode;
  logic          err_overflow;
  int            compareCount = 0;
  int            failCount = 0;
  int            writeCount = 0;
  int            writeMark;

  instr_encoder_loader_if #(.ADDR_WIDTH(AW)) bus ();

  instr_encoder_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(4)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .finish       (finish),
    .bus          (bus.slave),
    .busy         (busy),
    .done         (done),
    .word_count   (word_count),
    .err_opcode   (err_opcode),
    .err_overflow (err_overflow)
  );

  always #5 clock = ~clock;

  always @(negedge clock)
    if (bus.imem_we === 1'b1) writeCount++;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [4:0] op, input logic [4:0] rd,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] shamt,
                               input logic [4:0] aluop, input logic [16:0] imm, input logic [26:0] target);
    bus.in_valid  = valid;
    bus.in_opcode = op;
    bus.in_rd     = rd;
    bus.in_rs     = rs;
    bus.in_rt     = rt;
    bus.in_shamt  = shamt;
    bus.in_aluop  = aluop;
    bus.in_imm    = imm;
    bus.in_target = target;
  endtask

  task automatic checkWrite(input string tag, input logic [AW-1:0] addr, input logic [31:0] data);
    checkOutput({tag, "_we"}, 32'(bus.imem_we), 32'd1);
    checkOutput({tag, "_addr"}, 32'(bus.imem_addr), 32'(addr));
    checkOutput({tag, "_data"}, bus.imem_data, data);
  endtask

  // Finish an open LOAD session with no bundle in flight and return to IDLE.
  task automatic closeSession();
    finish = 1'b1;
    tick();
    finish = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    finish  = 1'b0;
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0);

    // Reset and empty session
    tick();
    tick();
    checkOutput("rst_we", 32'(bus.imem_we), 32'd0);
    checkOutput("rst_addr", 32'(bus.imem_addr), 32'd0);
    checkOutput("rst_data", bus.imem_data, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("rst_count", 32'(word_count), 32'd0);
    checkOutput("rst_errs", {30'd0, err_opcode, err_overflow}, 32'd0);
    reset_n = 1'b1;
    tick();
    writeMark = writeCount;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("empty_busy_load", 32'(busy), 32'd1);
    checkOutput("empty_ready_load", 32'(bus.in_ready), 32'd1);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    checkOutput("empty_busy_drain", 32'(busy), 32'd1);
    checkOutput("empty_ready_drain", 32'(bus.in_ready), 32'd0);
    checkOutput("empty_done_drain", 32'(done), 32'd0);
    tick();
    checkOutput("empty_done", 32'(done), 32'd1);
    checkOutput("empty_busy_done", 32'(busy), 32'd1);
    tick();
    checkOutput("empty_done_after", 32'(done), 32'd0);
    checkOutput("empty_busy_idle", 32'(busy), 32'd0);
    checkOutput("empty_count", 32'(word_count), 32'd0);
    checkOutput("empty_writes", 32'(writeCount - writeMark), 32'd0);

    // All four encodings, back to back
    start = 1'b1;
    tick();
    start = 1'b0;
    applyStimulus(1'b1, 5'b00101, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 17'h1FFFF, 27'd0);
    tick();
    checkWrite("enc_addi", 12'd0, 32'h2845FFFF);
    applyStimulus(1'b1, 5'b00000, 5'd3, 5'd1, 5'd2, 5'd0, 5'd0, 17'd0, 27'd0);
    tick();
    checkWrite("enc_radd", 12'd1, 32'h00C22000);
    applyStimulus(1'b1, 5'b00001, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'h0000010);
    tick();
    checkWrite("enc_j", 12'd2, 32'h08000010);
    applyStimulus(1'b1, 5'b00100, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0);
    tick();
    checkWrite("enc_jr", 12'd3, 32'h27C00000);
    checkOutput("enc_count_mid", 32'(word_count), 32'd3);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0);
    tick();
    checkOutput("enc_we_off", 32'(bus.imem_we), 32'd0);
    checkOutput("enc_count", 32'(word_count), 32'd4);
    checkOutput("enc_ready_full", 32'(bus.in_ready), 32'd0);
    checkOutput("enc_hold_data", bus.imem_data, 32'h27C00000);
    closeSession();

    // Unsupported opcode between two good bundles
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("bad_count_clear", 32'(word_count), 32'd0);
    applyStimulus(1'b1, 5'b00101, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 17'd5, 27'd0);
    tick();
    checkWrite("bad_first", 12'd0, 32'h28440005);
    applyStimulus(1'b1, 5'b11111, 5'd7, 5'd7, 5'd7, 5'd7, 5'd7, 17'h1234, 27'h55);
    tick();
    checkOutput("bad_no_write", 32'(bus.imem_we), 32'd0);
    checkOutput("bad_err", 32'(err_opcode), 32'd1);
    applyStimulus(1'b1, 5'b00111, 5'd2, 5'd3, 5'd0, 5'd0, 5'd0, 17'd7, 27'd0);
    tick();
    checkWrite("bad_second", 12'd1, 32'h38860007);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0);
    tick();
    checkOutput("bad_count", 32'(word_count), 32'd2);
    closeSession();
    checkOutput("bad_err_hold", 32'(err_opcode), 32'd1);

    // Full session with in_valid held for six bundles
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("full_errop_clear", 32'(err_opcode), 32'd0);
    writeMark = writeCount;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 5'b01000, 5'd5, 5'd6, 5'd0, 5'd0, 5'd0, 17'(i), 27'd0);
      tick();
      if (i < 4) checkWrite($sformatf("full_w%0d", i), 12'(i), 32'h414C0000 | 32'(i));
    end
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0);
    tick();
    checkOutput("full_writes", 32'(writeCount - writeMark), 32'd4);
    checkOutput("full_count", 32'(word_count), 32'd4);
    checkOutput("full_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("full_overflow", 32'(err_overflow), 32'd1);
    checkOutput("full_last_addr", 32'(bus.imem_addr), 32'd3);
    closeSession();
    checkOutput("full_overflow_hold", 32'(err_overflow), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("full_overflow_clear", 32'(err_overflow), 32'd0);
    checkOutput("full_count_clear", 32'(word_count), 32'd0);

    // Finish together with a beat; start ignored while busy
    applyStimulus(1'b1, 5'b01000, 5'd5, 5'd6, 5'd0, 5'd0, 5'd0, 17'h10, 27'd0);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0);
    checkWrite("fin_beat", 12'd0, 32'h414C0010);
    checkOutput("fin_ready_drain", 32'(bus.in_ready), 32'd0);
    start = 1'b1;
    tick();
    checkOutput("fin_we_off", 32'(bus.imem_we), 32'd0);
    checkOutput("fin_done_wait", 32'(done), 32'd0);
    checkOutput("fin_busy", 32'(busy), 32'd1);
    tick();
    checkOutput("fin_done", 32'(done), 32'd1);
    checkOutput("fin_count", 32'(word_count), 32'd1);
    tick();
    start = 1'b0;
    checkOutput("fin_idle", 32'(busy), 32'd0);
    checkOutput("fin_done_off", 32'(done), 32'd0);

    // Reset right after a consume
    start = 1'b1;
    tick();
    start = 1'b0;
    applyStimulus(1'b1, 5'b00101, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 17'h1FFFF, 27'd0);
    tick();
    checkWrite("mid_consume", 12'd0, 32'h2845FFFF);
    reset_n = 1'b0;
    tick();
    checkOutput("mid_we", 32'(bus.imem_we), 32'd0);
    checkOutput("mid_busy", 32'(busy), 32'd0);
    checkOutput("mid_count", 32'(word_count), 32'd0);
    checkOutput("mid_addr", 32'(bus.imem_addr), 32'd0);
    checkOutput("mid_data", bus.imem_data, 32'd0);
    checkOutput("mid_ready", 32'(bus.in_ready), 32'd0);
    reset_n = 1'b1;
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0);
    tick();
    checkOutput("mid_we_after", 32'(bus.imem_we), 32'd0);
    checkOutput("mid_idle_after", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
